// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter stage for the pipelined core.
//
// Holds the fetch PC and offers it to instruction fetch through a valid/ready
// handshake. The next PC is chosen by priority: reset, trap, redirect, return
// prediction, increment, hold. Misaligned redirect targets are rejected and
// reported.
//
// Optional feature macro: PC_RAS_EN
//   defined   -> circular return-address stack of RAS_DEPTH entries
//   undefined -> no RAS; call_i/ret_i ignored; ras_empty_o tied high
//   The port list is identical in both builds.
//
// Parameters
//   XLEN          PC width in bits
//   RESET_VECTOR  PC loaded by reset (INST_BYTES aligned)
//   INST_BYTES    sequential increment and alignment granule (power of 2)
//   RAS_DEPTH     return-address-stack entries (power of 2, >= 2)
//
// Ports
//   clk, reset         clock (rising edge), synchronous active-high reset
//   stall_i            hold PC
//   fetch_ready_i      fetch accepts fetch_pc_o this cycle
//   redirect_valid_i   taken branch/jump, target on redirect_target_i
//   trap_valid_i       exception/interrupt entry, target on trap_vector_i
//   call_i, ret_i      accepted instruction is a call / return
//   fetch_pc_o         current fetch PC
//   fetch_valid_o      fetch_pc_o is valid
//   misalign_o         one-cycle pulse for a rejected misaligned redirect
//   misalign_addr_o    last rejected target
//   ras_empty_o        RAS holds no entries
module pc_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INST_BYTES   = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] fetch_pc_o,
    output logic            fetch_valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o,
    output logic            ras_empty_o
);

    localparam logic [XLEN-1:0] INC        = XLEN'(INST_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INST_BYTES - 1);

    logic            acc;
    logic            steer;
    logic            target_misaligned;
    logic [XLEN-1:0] seq_pc;
    logic            ras_taken;
    logic [XLEN-1:0] ras_target;

    assign acc               = fetch_valid_o & fetch_ready_i & ~stall_i;
    assign steer             = trap_valid_i | redirect_valid_i;
    assign seq_pc            = fetch_pc_o + INC;
    assign target_misaligned = (redirect_target_i & ALIGN_MASK) != '0;

`ifdef PC_RAS_EN
    localparam int unsigned    PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned    CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras [RAS_DEPTH];
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] ras_count;
    logic             ras_nonempty;
    logic             pop_hit;
    logic             push_req;

    // ras_ptr is the next write slot; the top of stack sits just below it.
    assign top_idx      = ras_ptr - PTR_W'(1);
    assign ras_nonempty = ras_count != '0;
    // A trap or redirect (even a rejected one) suppresses all stack activity.
    assign pop_hit      = ~steer & acc & ret_i & ras_nonempty;
    assign push_req     = ~steer & acc & call_i;
    assign ras_taken    = pop_hit;
    assign ras_target   = ras[top_idx];
    assign ras_empty_o  = ~ras_nonempty;

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr   <= '0;
            ras_count <= '0;
        end else if (pop_hit && !push_req) begin
            ras_ptr   <= top_idx;
            ras_count <= ras_count - CNT_W'(1);
        end else if (push_req && !pop_hit) begin
            // When full the write slot holds the oldest entry, so it is overwritten.
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_count != FULL) begin
                ras_count <= ras_count + CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by ras_count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (pop_hit && push_req) begin
                ras[top_idx] <= seq_pc;
            end else if (push_req) begin
                ras[ras_ptr] <= seq_pc;
            end
        end
    end
`else
    logic unused_ras_inputs;

    assign unused_ras_inputs = call_i ^ ret_i;
    assign ras_taken         = 1'b0;
    assign ras_target        = '0;
    assign ras_empty_o       = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_o      <= RESET_VECTOR;
            fetch_valid_o   <= 1'b0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
        end else begin
            fetch_valid_o <= 1'b1;
            misalign_o    <= 1'b0;
            if (trap_valid_i) begin
                fetch_pc_o <= trap_vector_i;
            end else if (redirect_valid_i) begin
                if (target_misaligned) begin
                    misalign_o      <= 1'b1;
                    misalign_addr_o <= redirect_target_i;
                end else begin
                    fetch_pc_o <= redirect_target_i;
                end
            end else if (ras_taken) begin
                fetch_pc_o <= ras_target;
            end else if (acc) begin
                fetch_pc_o <= seq_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- self-checking bench for pc_sequencer (XLEN=32, reset vector 0).
// Each vector record holds one cycle of inputs and the outputs expected after
// the following rising edge. Records are pushed to a scoreboard queue when
// driven and popped for comparison half a cycle after the edge.
// Define PC_RAS_EN for both bench and design to exercise the return stack.
module tb_pc_sequencer;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        ready;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tvec;
        logic        call;
        logic        ret;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_mis;
        logic [31:0] e_maddr;
        logic        e_empty;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i;
    logic        fetch_ready_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        trap_valid_i;
    logic [31:0] trap_vector_i;
    logic        call_i;
    logic        ret_i;
    logic [31:0] fetch_pc_o;
    logic        fetch_valid_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
    logic        ras_empty_o;

    int   total = 0;
    int   bad   = 0;
    int   vec_no = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    pc_sequencer #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_0000),
        .INST_BYTES  (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_i          (stall_i),
        .fetch_ready_i    (fetch_ready_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_target_i(redirect_target_i),
        .trap_valid_i     (trap_valid_i),
        .trap_vector_i    (trap_vector_i),
        .call_i           (call_i),
        .ret_i            (ret_i),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_valid_o    (fetch_valid_o),
        .misalign_o       (misalign_o),
        .misalign_addr_o  (misalign_addr_o),
        .ras_empty_o      (ras_empty_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input logic rst, input logic stall, input logic ready,
                               input logic rv, input logic [31:0] rt,
                               input logic tv, input logic [31:0] tvec,
                               input logic call, input logic ret,
                               input logic [31:0] e_pc, input logic e_valid,
                               input logic e_mis, input logic [31:0] e_maddr,
                               input logic e_empty);
        vec_t r;
        r.rst = rst; r.stall = stall; r.ready = ready; r.rv = rv; r.rt = rt;
        r.tv = tv; r.tvec = tvec; r.call = call; r.ret = ret;
        r.e_pc = e_pc; r.e_valid = e_valid; r.e_mis = e_mis;
        r.e_maddr = e_maddr; r.e_empty = e_empty;
        return r;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL vec%0d %s: got %h want %h", vec_no, name, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL vec%0d scoreboard: got empty queue want entry", vec_no);
            return;
        end
        e = exp_q.pop_front();
        cmp("fetch_pc",    fetch_pc_o,             e.e_pc);
        cmp("fetch_valid", {31'b0, fetch_valid_o}, {31'b0, e.e_valid});
        cmp("misalign",    {31'b0, misalign_o},    {31'b0, e.e_mis});
        cmp("misalign_addr", misalign_addr_o,      e.e_maddr);
        cmp("ras_empty",   {31'b0, ras_empty_o},   {31'b0, e.e_empty});
    endtask

    // Drive one cycle of inputs (called just after a falling edge), then
    // compare after the next rising edge, away from it.
    task automatic apply(input vec_t x);
        reset             = x.rst;
        stall_i           = x.stall;
        fetch_ready_i     = x.ready;
        redirect_valid_i  = x.rv;
        redirect_target_i = x.rt;
        trap_valid_i      = x.tv;
        trap_vector_i     = x.tvec;
        call_i            = x.call;
        ret_i             = x.ret;
        exp_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        check_out();
        vec_no++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // rst stl rdy rv  rt            tv  tvec        call ret  pc             vld mis maddr         empty
        tbl.push_back(v(1, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0,   1));
        tbl.push_back(v(1, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0,   1));
        // leaving reset: valid rises, PC not yet accepted
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h4,         1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h8,         1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'hC,         1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h10,        1, 0, 32'h0,   1));
        // stall holds, then ready low holds
        tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h10,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h10,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h10,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h14,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h14,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h14,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h14,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h18,        1, 0, 32'h0,   1));
        // trap beats redirect; redirect ignores stall and ready
        tbl.push_back(v(0, 0, 1, 1, 32'h200,       1, 32'h80,  0, 0, 32'h80,        1, 0, 32'h0,   1));
        tbl.push_back(v(0, 1, 1, 1, 32'h200,       0, 32'h0,   0, 0, 32'h200,       1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 0, 1, 32'h40,        0, 32'h0,   0, 0, 32'h40,        1, 0, 32'h0,   1));
        // misaligned redirect: hold, pulse, capture address
        tbl.push_back(v(0, 0, 1, 1, 32'h102,       0, 32'h0,   0, 0, 32'h40,        1, 1, 32'h102, 1));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h40,        1, 0, 32'h102, 1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h44,        1, 0, 32'h102, 1));
        tbl.push_back(v(0, 0, 1, 1, 32'h103,       1, 32'h80,  0, 0, 32'h80,        1, 0, 32'h102, 1));
        // trap vector takes no alignment check
        tbl.push_back(v(0, 1, 0, 0, 32'h0,         1, 32'h82,  0, 0, 32'h82,        1, 0, 32'h102, 1));
        tbl.push_back(v(0, 0, 1, 1, 32'h106,       0, 32'h0,   0, 0, 32'h82,        1, 1, 32'h106, 1));
        // wrap at top of address space
        tbl.push_back(v(0, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,   0, 0, 32'hFFFF_FFFC, 1, 0, 32'h106, 1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         1, 0, 32'h106, 1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h4,         1, 0, 32'h106, 1));
        // reset beats a same-cycle redirect
        tbl.push_back(v(1, 0, 1, 1, 32'h300,       0, 32'h0,   0, 0, 32'h0,         0, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,         1, 0, 32'h0,   1));
        tbl.push_back(v(0, 0, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h4,         1, 0, 32'h0,   1));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

`ifdef PC_RAS_EN
        // call at 0x100, redirect away, return predicts 0x104
        apply(v(0, 0, 1, 1, 32'h100,  0, 32'h0,  0, 0, 32'h100,  1, 0, 32'h0, 1));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h104,  1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 1, 32'h400,  0, 32'h0,  0, 1, 32'h400,  1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 0, 32'h404,  1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h104,  1, 0, 32'h0, 1));
        // ret on empty stack falls through to increment
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h108,  1, 0, 32'h0, 1));
        // five calls into a depth-4 stack, then four returns newest first
        apply(v(0, 0, 1, 1, 32'h1000, 0, 32'h0,  0, 0, 32'h1000, 1, 0, 32'h0, 1));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h1004, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h1008, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h100C, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h1010, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h1014, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h1014, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h1010, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h100C, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h1008, 1, 0, 32'h0, 1));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h100C, 1, 0, 32'h0, 1));
        // call and ret together swap the top entry
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h1010, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 1, 32'h1010, 1, 0, 32'h0, 0));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h1014, 1, 0, 32'h0, 1));
        // stalled call does not push; trap suppresses a call
        apply(v(0, 1, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h1014, 1, 0, 32'h0, 1));
        apply(v(0, 0, 1, 0, 32'h0,    1, 32'h80, 1, 0, 32'h80,   1, 0, 32'h0, 1));
`else
        // without the stack, call/ret are plain sequential instructions
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 0, 32'h8,    1, 0, 32'h0, 1));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'hC,    1, 0, 32'h0, 1));
        apply(v(0, 0, 1, 0, 32'h0,    0, 32'h0,  1, 1, 32'h10,   1, 0, 32'h0, 1));
        apply(v(0, 1, 1, 0, 32'h0,    0, 32'h0,  0, 1, 32'h10,   1, 0, 32'h0, 1));
`endif

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
